// File: rtl/serial_subtractor_3bit_pkg.sv
// Shared types and constants for the bit-serial subtractor: FSM states, LED field positions
// and the one-bit full-subtractor cell used by the datapath.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sub_state_t;

  localparam int BUSY_BIT   = 7;
  localparam int RESULT_LSB = 0;

  // Returns {borrow_out, difference} for a - b - borrow_in.
  function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
    return {(~a & b) | (~a & bin) | (b & bin), a ^ b ^ bin};
  endfunction

endpackage

// File: rtl/serial_subtractor_3bit_if.sv
// Board pin bundle: operand/display switches, start button and LED bank.
// The master side drives switches and button; the slave side drives the LEDs.
interface serial_subtractor_3bit_if;
  logic [7:0] sw;
  logic       btn_start;
  logic [7:0] led;

  modport master (output sw, output btn_start, input led);
  modport slave  (input sw, input btn_start, output led);
endinterface

// File: rtl/serial_subtractor_3bit_button_debouncer.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and rising-edge pulse.
// The level follows the raw input 2 + DEBOUNCE_CYCLES cycles after a clean edge; shorter glitches are dropped.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_rise  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_raw};
      btn_rise <= 1'b0;
      // Any sample matching the accepted level restarts the stability window.
      if (sync_q[1] == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt       <= '0;
        btn_level <= sync_q[1];
        btn_rise  <= sync_q[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_subtractor_3bit.sv
// Bit-serial A - B (LSB first) started by a debounced button; result shown on LEDs.
// Start to result: WIDTH shift cycles plus one DONE cycle; starts arriving while busy are dropped.
module serial_subtractor_3bit
  import sub_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_subtractor_3bit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   result;
  logic             start;
  logic             busy;
  logic [1:0]       fs;
  logic             btn_level_unused;
  logic             unused_sw6;

  assign unused_sw6 = bus.sw[6];

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (bus.btn_start),
    .btn_level(btn_level_unused),
    .btn_rise (start)
  );

  assign fs = full_sub(a_sr[0], b_sr[0], borrow);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= bus.sw[WIDTH-1:0];
            b_sr   <= bus.sw[2*WIDTH-1:WIDTH];
            borrow <= 1'b0;
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          diff_sr <= {fs[0], diff_sr[WIDTH-1:1]};
          borrow  <= fs[1];
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          // Final borrow is the sign bit of the two's-complement difference.
          result <= {borrow, diff_sr};
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    bus.led           = '0;
    bus.led[BUSY_BIT] = busy;
    if (bus.sw[7]) begin
      bus.led[2*WIDTH-1:0] = bus.sw[2*WIDTH-1:0];
    end else begin
      bus.led[RESULT_LSB +: WIDTH+1] = result;
    end
  end

endmodule

// File: tb/tb_serial_subtractor_3bit.sv
// Directed bench for serial_subtractor_3bit with a short debounce window.
module tb_serial_subtractor_3bit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   busy_rises;
  logic busy_q;
  logic [3:0] prev_res;

  serial_subtractor_3bit_if bus ();

  serial_subtractor_3bit #(
    .WIDTH          (3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    busy_q <= bus.led[7];
    if (bus.led[7] && !busy_q) busy_rises <= busy_rises + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press with operands a/b, wait for busy, measure its length, check the result, release.
  task automatic run_op(input logic [2:0] a, input logic [2:0] b, input logic [3:0] exp,
                        input logic disp, input logic scramble);
    int n;
    int rises0;
    logic [7:0] base;
    rises0 = busy_rises;
    bus.sw        = {disp, 1'b0, b, a};
    bus.btn_start = 1'b1;
    n = 0;
    while (!bus.led[7] && n < 40) begin
      tick(1);
      n++;
    end
    if (!bus.led[7]) begin
      check_eq("start_timeout", 32'd0, 32'd1);
      bus.btn_start = 1'b0;
      tick(12);
      return;
    end
    base = disp ? {2'b00, b, a} : {4'b0000, prev_res};
    check_eq("busy_led", bus.led, {24'd0, 8'h80 | base});
    if (scramble) bus.sw[5:0] = ~{b, a};
    n = 1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (!bus.led[7]) break;
      n++;
    end
    check_eq("busy_len", n, 4);
    check_eq("result_led", bus.led, disp ? {26'd0, b, a} : {28'd0, exp});
    prev_res = exp;
    tick(10);
    bus.btn_start = 1'b0;
    tick(12);
    check_eq("one_start_per_press", busy_rises - rises0, 1);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    busy_rises    = 0;
    busy_q        = 1'b0;
    prev_res      = 4'd0;
    rst_n         = 1'b0;
    bus.sw        = 8'h2B;
    bus.btn_start = 1'b0;
    tick(3);
    check_eq("reset_led", bus.led, 32'h00);
    rst_n = 1'b1;
    tick(2);

    run_op(3'd5, 3'd3, 4'h2, 1'b0, 1'b0);
    run_op(3'd3, 3'd5, 4'hE, 1'b0, 1'b0);
    run_op(3'd0, 3'd7, 4'h9, 1'b0, 1'b0);
    run_op(3'd7, 3'd7, 4'h0, 1'b0, 1'b0);
    run_op(3'd7, 3'd0, 4'h7, 1'b0, 1'b0);

    // Glitches of 1..3 cycles must be rejected.
    begin
      int rises0;
      rises0 = busy_rises;
      for (int w = 1; w <= 3; w++) begin
        bus.btn_start = 1'b1;
        tick(w);
        bus.btn_start = 1'b0;
        tick(8);
      end
      check_eq("bounce_no_start", busy_rises - rises0, 0);
      check_eq("bounce_result", bus.led, 32'h07);
    end

    run_op(3'd6, 3'd2, 4'h4, 1'b0, 1'b1);

    // Reset in the second SHIFT cycle.
    bus.sw        = 8'h15;
    bus.btn_start = 1'b1;
    begin
      int n;
      n = 0;
      while (!bus.led[7] && n < 40) begin
        tick(1);
        n++;
      end
      check_eq("rst_busy_seen", bus.led[7], 1);
    end
    tick(1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_op_led", bus.led, 32'h00);
    bus.btn_start = 1'b0;
    tick(3);
    rst_n = 1'b1;
    prev_res = 4'd0;
    tick(3);
    check_eq("post_rst_idle", bus.led, 32'h00);
    run_op(3'd6, 3'd1, 4'h5, 1'b0, 1'b0);

    run_op(3'd2, 3'd4, 4'hE, 1'b1, 1'b0);
    check_eq("disp_live", bus.led, 32'h22);
    bus.sw[7] = 1'b0;
    #1;
    check_eq("disp_result", bus.led, 32'h0E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
